// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N:1 selector with registered valid/ready output and 2-entry skid buffer
module mux_pipe_n #(
  parameter int WIDTH         = 32,
  parameter int NUM_INPUTS    = 3,
  parameter int SEL_W         = 2,
  parameter int DEFAULT_VALUE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_oob,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        flush
);
  localparam int NSEL = 2 ** SEL_W;
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_VALUE);
  logic [WIDTH-1:0] tab [NSEL];
  logic [NSEL-1:0]  oob_tab;
  logic [WIDTH-1:0] sel_data, main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic             sel_oob, main_oob_q, main_oob_d, skid_oob_q, skid_oob_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic             accept, xfer, load;
  // every select code maps to a real input or, past NUM_INPUTS, to the default constant
  for (genvar k = 0; k < NSEL; k++) begin : g_tab
    if (k < NUM_INPUTS) begin : g_in
      assign tab[k]     = in_data[k*WIDTH +: WIDTH];
      assign oob_tab[k] = 1'b0;
    end else begin : g_def
      assign tab[k]     = DEF;
      assign oob_tab[k] = 1'b1;
    end
  end
  assign sel_data  = tab[in_sel];
  assign sel_oob   = oob_tab[in_sel];
  assign accept    = in_valid & rdy_q;
  assign xfer      = main_vld_q & out_ready;
  assign load      = ~main_vld_q | xfer;
  assign in_ready  = rdy_q;
  assign out_data  = main_data_q;
  assign out_oob   = main_oob_q;
  assign out_valid = main_vld_q;
  // main refills from skid first (older beat), else from the incoming beat; skid only catches a beat main cannot take
  always_comb begin
    main_vld_d  = flush ? 1'b0 : (load ? (skid_vld_q | accept) : 1'b1);
    main_data_d = (load & skid_vld_q) ? skid_data_q : ((load & accept) ? sel_data : main_data_q);
    main_oob_d  = (load & skid_vld_q) ? skid_oob_q  : ((load & accept) ? sel_oob  : main_oob_q);
    skid_vld_d  = ~flush & ~load & (skid_vld_q | accept);
    skid_data_d = (~load & accept) ? sel_data : skid_data_q;
    skid_oob_d  = (~load & accept) ? sel_oob  : skid_oob_q;
    rdy_d       = ~skid_vld_d;
  end
  // state registers; ready comes up on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_oob_q  <= 1'b0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_oob_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_oob_q  <= main_oob_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_oob_q  <= skid_oob_d;
      skid_vld_q  <= skid_vld_d;
      rdy_q       <= rdy_d;
    end
  end
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: directed and randomized checks of mux_pipe_n against a queue model
module tb_mux_pipe_n;
  localparam logic [31:0] DEF32 = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid, in_ready, out_oob, out_valid, out_ready, flush;
  logic [31:0] out_data;
  logic [14:0] d5_in;
  logic [1:0]  d5_sel;
  logic        d5_valid, d5_in_ready, d5_oob, d5_out_valid, d5_out_ready, d5_flush;
  logic [4:0]  d5_out;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .DEFAULT_VALUE(32'hDEAD_BEEF)) u32 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_oob(out_oob), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush));

  mux_pipe_n #(.WIDTH(5), .NUM_INPUTS(3), .SEL_W(2), .DEFAULT_VALUE(31)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5_in), .in_sel(d5_sel), .in_valid(d5_valid),
    .in_ready(d5_in_ready), .out_data(d5_out), .out_oob(d5_oob), .out_valid(d5_out_valid),
    .out_ready(d5_out_ready), .flush(d5_flush));

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_oob, out_data} !== 34'd0) begin
      n_bad++; $display("FAIL reset32: got v=%b o=%b d=%h, want all 0", out_valid, out_oob, out_data);
    end
    n_cmp++;
    if ({d5_out_valid, d5_oob, d5_out} !== 7'd0) begin
      n_bad++; $display("FAIL reset5: got v=%b o=%b d=%h, want all 0", d5_out_valid, d5_oob, d5_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || d5_in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got rdy=%b rdy5=%b v=%b, want 1 1 0", in_ready, d5_in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    in_data = {32'h33, 32'h22, 32'h11};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sel = 2'(i);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_oob !== 1'b0 || out_data !== 32'h11 * (i + 1)) begin
        n_bad++; $display("FAIL basic[%0d]: got v=%b o=%b d=%h, want v=1 o=0 d=%h", i, out_valid, out_oob, out_data, 32'h11 * (i + 1));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_default();
    d5_in = {5'd3, 5'd7, 5'd1};
    d5_out_ready = 1'b1;
    d5_valid = 1'b1;
    d5_sel = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (d5_out_valid !== 1'b1 || d5_out !== 5'd31 || d5_oob !== 1'b1) begin
      n_bad++; $display("FAIL default_oob: got v=%b d=%0d o=%b, want 1 31 1", d5_out_valid, d5_out, d5_oob);
    end
    d5_sel = 2'd1;
    @(negedge clk);
    n_cmp++;
    if (d5_out_valid !== 1'b1 || d5_out !== 5'd7 || d5_oob !== 1'b0) begin
      n_bad++; $display("FAIL default_in1: got v=%b d=%0d o=%b, want 1 7 0", d5_out_valid, d5_out, d5_oob);
    end
    d5_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = {3{32'hA}};
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      n_bad++; $display("FAIL bp_a: got v=%b d=%h, want 1 a", out_valid, out_data);
    end
    out_ready = 1'b0; in_data = {3{32'hB}};
    @(negedge clk);
    in_data = {3{32'hC}};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h, want 0 1 a", i, in_ready, out_valid, out_data);
      end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hB) begin
      n_bad++; $display("FAIL bp_b: got rdy=%b v=%b d=%h, want 1 1 b", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hC) begin
      n_bad++; $display("FAIL bp_c: got v=%b d=%h, want 1 c", out_valid, out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_end: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = {3{32'h1}};
    @(negedge clk);
    in_data = {3{32'h2}};
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_fill: got rdy=%b v=%b, want 0 1", in_ready, out_valid);
    end
    flush = 1'b1; in_data = {3{32'hD}};
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_full: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_quiet[%0d]: got v=%b d=%h, want v=0", i, out_valid, out_data);
      end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = {3{32'hE}};
    @(negedge clk);
    flush = 1'b1; in_data = {3{32'hF}};
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_main: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_offer: got v=%b d=%h, want v=0", out_valid, out_data);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_sel = 2'd3; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_oob !== 1'b1 || out_data !== DEF32) begin
      n_bad++; $display("FAIL arst_pre: got v=%b o=%b d=%h, want 1 1 %h", out_valid, out_oob, out_data, DEF32);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_oob, out_data} !== 34'd0) begin
      n_bad++; $display("FAIL arst_async: got v=%b o=%b d=%h, want all 0", out_valid, out_oob, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL arst_release: got rdy=%b v=%b, want 1 0", in_ready, out_valid);
    end
    in_valid = 1'b1; in_sel = 2'd2; in_data = {32'h77, 32'h66, 32'h55};
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || out_oob !== 1'b0) begin
      n_bad++; $display("FAIL arst_first: got v=%b o=%b d=%h, want 1 0 77", out_valid, out_oob, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n_beats, input bit full);
    logic [32:0] q[$];
    logic [32:0] exp;
    int acc_n = 0;
    int xf_obs = 0;
    bit acc, xf;
    while (acc_n < n_beats || q.size() > 0) begin
      n_cmp++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        n_bad++; $display("FAIL rand_hs: got v=%b rdy=%b, want v=%b rdy=%b", out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({out_oob, out_data} !== q[0]) begin
          n_bad++; $display("FAIL rand_data: got o=%b d=%h, want o=%b d=%h", out_oob, out_data, q[0][32], q[0][31:0]);
        end
      end
      in_data   = {$urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = (acc_n < n_beats) && (full || $urandom_range(0, 3) != 0);
      out_ready = full || acc_n >= n_beats || $urandom_range(0, 2) != 0;
      acc = in_valid && q.size() < 2;
      xf  = out_ready && q.size() > 0;
      if (out_valid === 1'b1 && out_ready) xf_obs++;
      exp = (in_sel < 3) ? {1'b0, 32'(in_data >> (in_sel * 32))} : {1'b1, DEF32};
      @(posedge clk);
      if (xf) void'(q.pop_front());
      if (acc) begin
        q.push_back(exp);
        acc_n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rand_drain: got v=%b, want 0", out_valid);
    end
    if (full) begin
      n_cmp++;
      if (xf_obs !== n_beats) begin
        n_bad++; $display("FAIL throughput: got %0d beats out in %0d cycles, want %0d", xf_obs, n_beats + 1, n_beats);
      end
    end
  endtask

  initial begin
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    d5_in = '0; d5_sel = '0; d5_valid = 1'b0; d5_out_ready = 1'b0; d5_flush = 1'b0;
    test_reset();
    test_basic();
    test_default();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random(10000, 1'b0);
    test_random(200, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
